ppi_bus_ctrl: RTL and testbench

Synchronous bus master that configures and sequences the ppi peripheral interface (rdb/wrb/address/data, 8255-style). After reset it holds the ppi in reset, then writes the mode control word. From then on it converts single-cycle host requests into timed ppi read/write strobes with programmable setup, pulse and hold. It sits between the system-side host bus and the ppi instance; tri-state resolution of data happens at the top level.

---
 rtl/ppi_pkg.sv | 25 ++
 rtl/ppi_bus_ctrl_if.sv | 35 +++
 rtl/ppi_bus_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ppi_bus_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared types and constants for the ppi bus controller.
package ppi_pkg;

  localparam int unsigned PPI_AW = 3;
  localparam int unsigned PPI_DW = 8;

  localparam logic [PPI_AW-1:0] PORTA = 3'd0;
  localparam logic [PPI_AW-1:0] PORTB = 3'd1;
  localparam logic [PPI_AW-1:0] PORTC = 3'd2;
  localparam logic [PPI_AW-1:0] CTRL  = 3'd3;

  localparam int unsigned MODE_SET_BIT = 7;

  localparam logic [PPI_DW-1:0] DEF_CFG_WORD = 8'h80;

  typedef enum logic [2:0] {
    ST_RST,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE,
    ST_IDLE
  } state_e;

endpackage

// File: rtl/ppi_bus_ctrl_if.sv
// Host-side request bus and ppi-side strobe bus of the ppi bus controller.
interface ppi_bus_ctrl_if;
  import ppi_pkg::*;

  logic              req;
  logic              req_we;
  logic [PPI_AW-1:0] req_addr;
  logic [PPI_DW-1:0] req_wdata;
  logic              ack;
  logic              err;
  logic [PPI_DW-1:0] rdata;
  logic              busy;
  logic              cfg_done;
  logic [PPI_DW-1:0] mode_word;
  logic              ppi_reset;
  logic              rdb;
  logic              wrb;
  logic [PPI_AW-1:0] address;
  logic [PPI_DW-1:0] data_out;
  logic              data_oe;
  logic [PPI_DW-1:0] data_in;

  modport master (
    input  req, req_we, req_addr, req_wdata, data_in,
    output ack, err, rdata, busy, cfg_done, mode_word,
           ppi_reset, rdb, wrb, address, data_out, data_oe
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, data_in,
    input  ack, err, rdata, busy, cfg_done, mode_word,
           ppi_reset, rdb, wrb, address, data_out, data_oe
  );

endinterface

// File: rtl/ppi_bus_ctrl.sv
// ppi bus master: holds the ppi in reset, writes the mode word, then turns
// single-cycle host requests into timed rdb/wrb cycles. All outputs registered.
module ppi_bus_ctrl
  import ppi_pkg::*;
#(
  parameter int unsigned       SETUP_CYC  = 1,
  parameter int unsigned       STROBE_CYC = 2,
  parameter int unsigned       HOLD_CYC   = 1,
  parameter int unsigned       RST_CYC    = 4,
  parameter logic [PPI_DW-1:0] CFG_WORD   = DEF_CFG_WORD
) (
  input logic            clk,
  input logic            resetb,
  ppi_bus_ctrl_if.master bus
);

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] RST_LD    = 8'(RST_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              init_q, init_d;
  logic              we_q, we_d;
  logic [PPI_AW-1:0] addr_q, addr_d;
  logic [PPI_DW-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [PPI_DW-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              cfg_done_q, cfg_done_d;
  logic [PPI_DW-1:0] mode_word_q, mode_word_d;
  logic              ppi_reset_q, ppi_reset_d;
  logic              rdb_q, rdb_d;
  logic              wrb_q, wrb_d;
  logic [PPI_AW-1:0] address_q, address_d;
  logic [PPI_DW-1:0] data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;

  // Outputs are computed for the state being entered so they line up with it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_d      = init_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    cfg_done_d  = cfg_done_q;
    mode_word_d = mode_word_q;
    ppi_reset_d = ppi_reset_q;
    rdb_d       = rdb_q;
    wrb_d       = wrb_q;
    address_d   = address_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;

    unique case (state_q)
      ST_RST: begin
        if (cnt_q == '0) begin
          ppi_reset_d = 1'b0;
          init_d      = 1'b1;
          we_d        = 1'b1;
          addr_d      = CTRL;
          wdata_d     = CFG_WORD;
          address_d   = CTRL;
          data_out_d  = CFG_WORD;
          data_oe_d   = 1'b1;
          cnt_d       = SETUP_LD;
          state_d     = ST_SETUP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = STROBE_LD;
          state_d = ST_STROBE;
          if (we_q) wrb_d = 1'b0;
          else      rdb_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
          rdb_d   = 1'b1;
          wrb_d   = 1'b1;
          if (!we_q) rdata_d = bus.data_in;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          data_oe_d = 1'b0;
          if (init_q) cfg_done_d = 1'b1;
          else        ack_d      = 1'b1;
          if (we_q && addr_q == CTRL && wdata_q[MODE_SET_BIT]) mode_word_d = wdata_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        init_d  = 1'b0;
      end
      ST_IDLE: begin
        if (bus.req && cfg_done_q) begin
          busy_d  = 1'b1;
          init_d  = 1'b0;
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (bus.req_addr[PPI_AW-1]) begin
            state_d = ST_DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = ST_SETUP;
            cnt_d     = SETUP_LD;
            address_d = bus.req_addr;
            if (bus.req_we) begin
              data_out_d = bus.req_wdata;
              data_oe_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_RST;
      cnt_q       <= RST_LD;
      init_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b1;
      cfg_done_q  <= 1'b0;
      mode_word_q <= '0;
      ppi_reset_q <= 1'b1;
      rdb_q       <= 1'b1;
      wrb_q       <= 1'b1;
      address_q   <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
      mode_word_q <= mode_word_d;
      ppi_reset_q <= ppi_reset_d;
      rdb_q       <= rdb_d;
      wrb_q       <= wrb_d;
      address_q   <= address_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.cfg_done  = cfg_done_q;
  assign bus.mode_word = mode_word_q;
  assign bus.ppi_reset = ppi_reset_q;
  assign bus.rdb       = rdb_q;
  assign bus.wrb       = wrb_q;
  assign bus.address   = address_q;
  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;

endmodule

// File: tb/tb_ppi_bus_ctrl.sv
// Scoreboard bench for ppi_bus_ctrl: init sequence, host reads/writes, errors,
// request ordering rules and asynchronous reset.
module tb_ppi_bus_ctrl;

  localparam int unsigned T_SETUP  = 1;
  localparam int unsigned T_STROBE = 2;
  localparam int unsigned T_HOLD   = 1;
  localparam int unsigned T_RST    = 4;
  localparam logic [7:0]  T_CFG    = 8'h80;
  localparam int unsigned LAT      = 1 + T_SETUP + T_STROBE + T_HOLD;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic clk;
  logic resetb;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [7:0] model_rdata;
  logic [7:0] model_mode;

  ppi_bus_ctrl_if bus ();

  ppi_bus_ctrl #(
    .SETUP_CYC (T_SETUP),
    .STROBE_CYC(T_STROBE),
    .HOLD_CYC  (T_HOLD),
    .RST_CYC   (T_RST),
    .CFG_WORD  (T_CFG)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetb && !bus.rdb && !bus.wrb) begin
      errors++;
      $display("FAIL both_strobes rdb=%b wrb=%b required not both 0", bus.rdb, bus.wrb);
    end
    if (resetb && !bus.rdb && bus.data_oe) begin
      errors++;
      $display("FAIL oe_during_read data_oe=%b required 0", bus.data_oe);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Observes the init sequence; call right after resetb is released.
  task automatic run_init_check();
    int hi = 0, wl = 0, bad = 0, acks = 0;
    bit done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.ppi_reset) hi++;
      if (!bus.wrb) begin
        wl++;
        if (bus.address !== 3'd3 || bus.data_out !== T_CFG || bus.data_oe !== 1'b1) bad++;
      end
      if (!bus.rdb) bad++;
      if (bus.ack) acks++;
      if (bus.cfg_done) done = 1;
    end
    checks++; if (hi != T_RST) begin errors++; $display("FAIL init_ppi_reset_len got %0d exp %0d", hi, T_RST); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL init_cfg_done got %b exp 1", done); end
    checks++; if (wl != T_STROBE) begin errors++; $display("FAIL init_wrb_len got %0d exp %0d", wl, T_STROBE); end
    checks++; if (bad != 0) begin errors++; $display("FAIL init_bus_values bad=%0d exp 0", bad); end
    checks++; if (acks != 0) begin errors++; $display("FAIL init_no_ack got %0d exp 0", acks); end
    checks++; if (bus.mode_word !== T_CFG) begin errors++; $display("FAIL init_mode_word got %h exp %h", bus.mode_word, T_CFG); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL init_busy_idle got %b exp 0", bus.busy); end
    model_mode = T_CFG;
  endtask

  // Single host transaction with per-cycle strobe/oe/address tracking.
  task automatic do_txn(input bit we, input logic [2:0] a, input logic [7:0] wd);
    exp_t e, g;
    bit illegal = a[2];
    bit got = 0;
    int lat = 0, bad = 0, exp_lat;
    logic [31:0] wm = '0, rm = '0, om = '0, ewm = '0, erm = '0, eom = '0;
    e.err   = illegal;
    e.rdata = (!we && !illegal) ? bus.data_in : model_rdata;
    model_rdata = e.rdata;
    sb.push_back(e);
    if (we && a == 3'd3 && wd[7]) model_mode = wd;
    exp_lat = illegal ? 1 : LAT;
    if (!illegal) begin
      for (int c = 1 + T_SETUP; c <= T_SETUP + T_STROBE; c++) begin
        if (we) ewm[c] = 1'b1;
        else    erm[c] = 1'b1;
      end
      if (we) for (int c = 1; c <= T_SETUP + T_STROBE + T_HOLD; c++) eom[c] = 1'b1;
    end
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (!bus.wrb) wm[c] = 1'b1;
      if (!bus.rdb) rm[c] = 1'b1;
      if (bus.data_oe) begin
        om[c] = 1'b1;
        if (bus.data_out !== wd) bad++;
      end
      if (!illegal && (!bus.wrb || !bus.rdb || bus.data_oe) && bus.address !== a) bad++;
      if (bus.ack) begin got = 1; lat = c; end
    end
    bus.req = 1'b0;
    g = sb.pop_front();
    checks++; if (got !== 1'b1 || lat != exp_lat) begin errors++; $display("FAIL txn_latency a=%0d got %0d exp %0d", a, lat, exp_lat); end
    checks++; if (wm !== ewm) begin errors++; $display("FAIL txn_wrb_cycles a=%0d got %h exp %h", a, wm, ewm); end
    checks++; if (rm !== erm) begin errors++; $display("FAIL txn_rdb_cycles a=%0d got %h exp %h", a, rm, erm); end
    checks++; if (om !== eom) begin errors++; $display("FAIL txn_oe_cycles a=%0d got %h exp %h", a, om, eom); end
    checks++; if (bad != 0) begin errors++; $display("FAIL txn_addr_data a=%0d bad=%0d exp 0", a, bad); end
    checks++; if (bus.err !== g.err) begin errors++; $display("FAIL txn_err a=%0d got %b exp %b", a, bus.err, g.err); end
    checks++; if (bus.rdata !== g.rdata) begin errors++; $display("FAIL txn_rdata a=%0d got %h exp %h", a, bus.rdata, g.rdata); end
    checks++; if (bus.mode_word !== model_mode) begin errors++; $display("FAIL txn_mode_word got %h exp %h", bus.mode_word, model_mode); end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.ppi_reset !== 1'b1) begin errors++; $display("FAIL rst_ppi_reset got %b exp 1", bus.ppi_reset); end
    checks++; if (bus.rdb !== 1'b1 || bus.wrb !== 1'b1) begin errors++; $display("FAIL rst_strobes got %b%b exp 11", bus.rdb, bus.wrb); end
    checks++; if (bus.data_oe !== 1'b0 || bus.data_out !== 8'h00 || bus.address !== 3'd0) begin errors++; $display("FAIL rst_bus got oe=%b d=%h a=%0d exp 0", bus.data_oe, bus.data_out, bus.address); end
    checks++; if (bus.busy !== 1'b1 || bus.cfg_done !== 1'b0) begin errors++; $display("FAIL rst_status got busy=%b cfg=%b exp 1 0", bus.busy, bus.cfg_done); end
    checks++; if (bus.ack !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 8'h00 || bus.mode_word !== 8'h00) begin errors++; $display("FAIL rst_host got ack=%b err=%b rd=%h mw=%h exp 0", bus.ack, bus.err, bus.rdata, bus.mode_word); end
    @(posedge clk); #1 resetb = 1'b1;
    model_rdata = 8'h00;
    run_init_check();
  endtask

  task automatic test_write();
    do_txn(1'b1, 3'd1, 8'hA5);
  endtask

  task automatic test_read();
    bus.data_in = 8'h3C;
    do_txn(1'b0, 3'd2, 8'h00);
    bus.data_in = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (bus.rdata !== 8'h3C) begin errors++; $display("FAIL read_hold got %h exp 3c", bus.rdata); end
  endtask

  task automatic test_illegal_ctrl();
    do_txn(1'b1, 3'd5, 8'hEE);
    do_txn(1'b0, 3'd7, 8'h00);
    do_txn(1'b1, 3'd3, 8'h0F);
    do_txn(1'b1, 3'd3, 8'h9B);
  endtask

  task automatic test_req_drop();
    exp_t e, g;
    bit got = 0;
    int lat = 0;
    e.err = 1'b0; e.rdata = model_rdata;
    sb.push_back(e);
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 3'd2; bus.req_wdata = 8'h42;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 2) bus.req = 1'b0;
      if (bus.ack) begin got = 1; lat = c; end
    end
    g = sb.pop_front();
    checks++; if (got !== 1'b1 || lat != LAT) begin errors++; $display("FAIL drop_latency got %0d exp %0d", lat, LAT); end
    checks++; if (bus.err !== g.err || bus.rdata !== g.rdata) begin errors++; $display("FAIL drop_result got err=%b rd=%h exp %b %h", bus.err, bus.rdata, g.err, g.rdata); end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    int ackc = 0, t1 = 0, t2 = 0, starts = 0;
    e.err = 1'b0; e.rdata = model_rdata; sb.push_back(e);
    e.err = 1'b0; e.rdata = 8'h77;       sb.push_back(e);
    model_rdata = 8'h77;
    bus.data_in = 8'h77;
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 3'd0; bus.req_wdata = 8'h11;
    for (int c = 1; c <= 40 && ackc < 2; c++) begin
      @(negedge clk);
      if (ackc == 1 && c == t1 + 2 && bus.address === 3'd1 && bus.busy === 1'b1) starts++;
      if (bus.ack) begin
        g = sb.pop_front();
        ackc++;
        checks++; if (bus.rdata !== g.rdata || bus.err !== g.err) begin errors++; $display("FAIL b2b_result%0d got rd=%h err=%b exp %h %b", ackc, bus.rdata, bus.err, g.rdata, g.err); end
        if (ackc == 1) begin t1 = c; bus.req_we = 1'b0; bus.req_addr = 3'd1; end
        else t2 = c;
      end
    end
    bus.req = 1'b0;
    checks++; if (ackc != 2 || t2 - t1 != LAT + 1) begin errors++; $display("FAIL b2b_spacing got acks=%0d gap=%0d exp 2 %0d", ackc, t2 - t1, LAT + 1); end
    checks++; if (starts != 1) begin errors++; $display("FAIL b2b_second_start got %0d exp 1", starts); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_addr = 3'd0; bus.req_wdata = 8'hC3;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (!bus.wrb) found = 1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_wrb_seen got %b exp 1", found); end
    resetb = 1'b0;
    #1;
    checks++; if (bus.wrb !== 1'b1 || bus.data_oe !== 1'b0) begin errors++; $display("FAIL mid_async got wrb=%b oe=%b exp 1 0", bus.wrb, bus.data_oe); end
    checks++; if (bus.ppi_reset !== 1'b1 || bus.cfg_done !== 1'b0) begin errors++; $display("FAIL mid_status got prst=%b cfg=%b exp 1 0", bus.ppi_reset, bus.cfg_done); end
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetb = 1'b1;
    model_rdata = 8'h00;
    run_init_check();
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata_cleared got %h exp 00", bus.rdata); end
    do_txn(1'b1, 3'd3, 8'h8A);
  endtask

  task automatic test_early_req();
    exp_t e, g;
    bit seen_cfg = 0, got = 0;
    int early = 0, wl = 0;
    resetb = 1'b0;
    bus.data_in = 8'h5A;
    e.err = 1'b0; e.rdata = 8'h5A; sb.push_back(e);
    model_rdata = 8'h5A;
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_addr = 3'd0; bus.req_wdata = 8'h00;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 resetb = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (!bus.wrb && !seen_cfg) wl++;
      if (!bus.rdb && !seen_cfg) early++;
      if (bus.ack && !seen_cfg) early++;
      if (bus.cfg_done) seen_cfg = 1;
      if (bus.ack) got = 1;
    end
    bus.req = 1'b0;
    g = sb.pop_front();
    model_mode = T_CFG;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL early_ack got %b exp 1", got); end
    checks++; if (early != 0) begin errors++; $display("FAIL early_before_cfg got %0d exp 0", early); end
    checks++; if (wl != T_STROBE) begin errors++; $display("FAIL early_init_wrb got %0d exp %0d", wl, T_STROBE); end
    checks++; if (bus.rdata !== g.rdata || bus.err !== g.err) begin errors++; $display("FAIL early_result got rd=%h err=%b exp %h %b", bus.rdata, bus.err, g.rdata, g.err); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_rdata = 8'h00;
    model_mode = 8'h00;
    resetb = 1'b0;
    bus.req = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = 3'd0;
    bus.req_wdata = 8'h00;
    bus.data_in = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_illegal_ctrl();
    test_req_drop();
    test_back_to_back();
    test_reset_mid();
    test_early_req();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
